// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter time-sharing one alu between two requesters with registered response slots.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins ties).
module alu #(
  parameter int W = 32
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         br
);
  always_comb begin
    y  = a + b;
    br = 1'b0;
    case (op)
      4'd1:  y = a - b;
      4'd2:  y = a * b;
      4'd3:  y = a & b;
      4'd4:  y = a | b;
      4'd5:  y = a ^ b;
      4'd6:  y = a << b;
      4'd7:  y = a >> b;
      4'd8,
      4'd9:  y = {{(W-1){1'b0}}, a < b};
      4'd11: br = a == b;
      4'd12: br = a > b;
      4'd13: br = a < b;
      default: y = a + b;
    endcase
  end
endmodule

module alu_share_arb #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_result,
  output logic         rsp0_branch,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_result,
  output logic         rsp1_branch
);
  logic         e0, e1, is_br, alu_br;
  logic [3:0]   op;
  logic [W-1:0] a, b, y, res_n;
  assign e0 = req0_valid && (!rsp0_valid || rsp0_ready);
  assign e1 = req1_valid && (!rsp1_valid || rsp1_ready);
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign req0_ready = !rst && e0;
  assign req1_ready = !rst && e1 && !e0;
`else
  logic last;
  assign req0_ready = !rst && e0 && (!e1 || last);
  assign req1_ready = !rst && e1 && (!e0 || !last);
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= 1'b1;
    else if (req0_ready || req1_ready) last <= req1_ready;
`endif
  assign op = req1_ready ? req1_op : req0_op;
  assign a  = req1_ready ? req1_a  : req0_a;
  assign b  = req1_ready ? req1_b  : req0_b;
  alu #(.W(W)) u_alu (.op(op), .a(a), .b(b), .y(y), .br(alu_br));
  // Branch ops report only the decision; everything else only the value.
  assign is_br = op inside {4'd11, 4'd12, 4'd13};
  assign res_n = is_br ? '0 : y;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_branch <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_branch <= 1'b0;
    end else begin
      if (req0_ready) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= res_n;
        rsp0_branch <= is_br && alu_br;
      end else if (rsp0_ready) rsp0_valid <= 1'b0;
      if (req1_ready) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= res_n;
        rsp1_branch <= is_br && alu_br;
      end else if (rsp1_ready) rsp1_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and randomized checks of alu_share_arb against a queue-free slot model.
module tb_alu_share_arb;
  logic        clk = 1'b0, rst = 1'b1;
  logic        v[2], rdy[2], rv[2], rr[2], brc[2];
  logic [31:0] a[2], b[2], res[2];
  logic [3:0]  op[2];
  int          n_chk = 0, n_fail = 0;
  logic        m_v[2], m_br[2], m_last;
  logic [31:0] m_res[2];
  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_a(a[0]), .req0_b(b[0]), .req0_op(op[0]),
    .rsp0_valid(rv[0]), .rsp0_ready(rr[0]), .rsp0_result(res[0]), .rsp0_branch(brc[0]),
    .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_a(a[1]), .req1_b(b[1]), .req1_op(op[1]),
    .rsp1_valid(rv[1]), .rsp1_ready(rr[1]), .rsp1_result(res[1]), .rsp1_branch(brc[1])
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic br);
    r = 0;
    br = 0;
    if (o == 1) r = x - y;
    else if (o == 2) r = x * y;
    else if (o == 3) r = x & y;
    else if (o == 4) r = x | y;
    else if (o == 5) r = x ^ y;
    else if (o == 6) r = (y >= 32) ? 0 : x << y[4:0];
    else if (o == 7) r = (y >= 32) ? 0 : x >> y[4:0];
    else if (o == 8 || o == 9) r = (x < y) ? 1 : 0;
    else if (o == 11) br = (x == y);
    else if (o == 12) br = (x > y);
    else if (o == 13) br = (x < y);
    else r = x + y;
  endfunction

  function automatic logic [1:0] mgrant();
    logic e0, e1;
    e0 = v[0] && (!m_v[0] || rr[0]);
    e1 = v[1] && (!m_v[1] || rr[1]);
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (e0 && e1) return 2'b01;
`else
    if (e0 && e1) return m_last ? 2'b01 : 2'b10;
`endif
    return {e1, e0};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v = '{0, 0}; m_br = '{0, 0}; m_res = '{0, 0}; m_last = 1;
    end else begin
      logic [1:0] g;
      g = mgrant();
      for (int i = 0; i < 2; i++)
        if (g[i]) begin
          m_v[i] = 1;
          ref_alu(op[i], a[i], b[i], m_res[i], m_br[i]);
        end else if (rr[i]) m_v[i] = 0;
      if (g != 0) m_last = g[1];
    end
  end

  always @(negedge clk) begin
    logic [1:0] g;
    g = rst ? 2'b00 : mgrant();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready%0d", i), {31'b0, rdy[i]}, {31'b0, g[i]});
      chk($sformatf("rsp_valid%0d", i), {31'b0, rv[i]}, {31'b0, m_v[i]});
      chk($sformatf("rsp_result%0d", i), res[i], m_res[i]);
      chk($sformatf("rsp_branch%0d", i), {31'b0, brc[i]}, {31'b0, m_br[i]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic vv, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    v[i] = vv; op[i] = o; a[i] = x; b[i] = y;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      drive(i, 0, 0, 0, 0);
      rr[i] = 1;
    end
    drive(0, 1, 0, 5, 7);
    @(negedge clk);
    chk("ready0_in_reset", {31'b0, rdy[0]}, 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("add_ready", {31'b0, rdy[0]}, 1);
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("add_valid", {31'b0, rv[0]}, 1);
    chk("add_result", res[0], 12);
    chk("add_branch", {31'b0, brc[0]}, 0);
    step();
    drive(1, 1, 11, 32'h1234, 32'h1234);
    step();
    drive(1, 1, 13, 3, 2);
    @(negedge clk);
    chk("beq_branch", {31'b0, brc[1]}, 1);
    chk("beq_result", res[1], 0);
    step();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("blt_branch", {31'b0, brc[1]}, 0);
    chk("blt_valid", {31'b0, rv[1]}, 1);
    step();
    drive(0, 1, 1, 10, 3);
    drive(1, 1, 1, 10, 3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("tie_grant0", {31'b0, rdy[0]}, 1);
`else
      chk("tie_grant0", {31'b0, rdy[0]}, (k % 2 == 0) ? 1 : 0);
      chk("tie_grant1", {31'b0, rdy[1]}, (k % 2 == 1) ? 1 : 0);
`endif
      if (k > 0 && rv[0]) chk("tie_res0", res[0], 7);
      if (k > 1 && rv[1]) chk("tie_res1", res[1], 7);
      step();
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    step();
    drive(0, 1, 0, 5, 7);
    rr[0] = 0;
    step();
    drive(0, 1, 5, 32'hF0, 32'h0F);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_ready0", {31'b0, rdy[0]}, 0);
      chk("bp_hold", res[0], 12);
      step();
    end
    rr[0] = 1;
    @(negedge clk);
    chk("bp_release_ready", {31'b0, rdy[0]}, 1);
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_xor", res[0], 32'hFF);
    chk("bp_valid", {31'b0, rv[0]}, 1);
    step();
    drive(1, 1, 2, 6, 7);
    rr[1] = 0;
    step();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 1);
    rr[0] = 0;
    @(negedge clk);
    chk("mul_result", res[1], 42);
    step();
    drive(0, 0, 0, 0, 0);
    #2 rst = 1;
    #1;
    chk("rst_valid0", {31'b0, rv[0]}, 0);
    chk("rst_valid1", {31'b0, rv[1]}, 0);
    chk("rst_result0", res[0], 0);
    chk("rst_result1", res[1], 0);
    step();
    rst = 0;
    rr[0] = 1; rr[1] = 1;
    drive(0, 1, 1, 10, 3);
    drive(1, 1, 1, 10, 3);
    @(negedge clk);
    chk("post_rst_tie0", {31'b0, rdy[0]}, 1);
    chk("post_rst_tie1", {31'b0, rdy[1]}, 0);
    step();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] x, y;
        x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom;
        y = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom;
        if ($urandom_range(0, 7) == 0) y = x;
        drive(i, $urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), x, y);
        rr[i] = $urandom_range(0, 9) < 6;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1;
        #1 rst = 0;
      end
      step();
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
